// File: rtl/ysyx_23060191_wbu_pipe_if.sv
// ============================================================================
// Module   : ysyx_23060191_wbu_pipe_if
// Brief    : LSU -> WBU instruction handshake bundle (valid/ready + payload)
// Revision : 1.0
// ============================================================================
`default_nettype none

interface ysyx_23060191_wbu_pipe_if #(
    parameter int CPU_WIDTH = 32,
    parameter int REG_AW    = 5
);
    localparam int OFF_W = $clog2(CPU_WIDTH / 8);

    logic                 in_valid;
    logic                 in_ready;
    logic [CPU_WIDTH-1:0] in_pc;
    logic [CPU_WIDTH-1:0] in_exu_res;
    logic [CPU_WIDTH-1:0] in_lsu_rdata;
    logic [CPU_WIDTH-1:0] in_csr_rdata;
    logic [OFF_W-1:0]     in_addr_lo;
    logic [1:0]           in_wb_sel;
    logic [2:0]           in_ld_fmt;
    logic [REG_AW-1:0]    in_rd;
    logic                 in_rd_wen;

    modport master (
        output in_valid, in_pc, in_exu_res, in_lsu_rdata, in_csr_rdata,
               in_addr_lo, in_wb_sel, in_ld_fmt, in_rd, in_rd_wen,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_pc, in_exu_res, in_lsu_rdata, in_csr_rdata,
               in_addr_lo, in_wb_sel, in_ld_fmt, in_rd, in_rd_wen,
        output in_ready
    );
endinterface

`default_nettype wire

// File: rtl/ysyx_23060191_wbu_pipe.sv
// ============================================================================
// Module   : ysyx_23060191_wbu_pipe
// Brief    : registered writeback stage; optional difftest trace via
//            YSYX_23060191_WBU_TRACE_EN
// Revision : 1.0
// ============================================================================
`default_nettype none

module ysyx_23060191_wbu_pipe #(
    parameter int CPU_WIDTH = 32,
    parameter int REG_AW    = 5,
    parameter int CNT_W     = 64
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    ysyx_23060191_wbu_pipe_if.slave   up,
    input  wire logic                 out_ready,
    output logic                      rf_wen,
    output logic [REG_AW-1:0]         rf_waddr,
    output logic [CPU_WIDTH-1:0]      rf_wdata,
    output logic                      retire,
    output logic [CNT_W-1:0]          retire_cnt
`ifdef YSYX_23060191_WBU_TRACE_EN
    ,
    output logic                      trace_valid,
    output logic [CPU_WIDTH-1:0]      trace_pc,
    output logic [REG_AW-1:0]         trace_rd,
    output logic [CPU_WIDTH-1:0]      trace_wdata
`endif
);

    logic                 vld_q;
    logic                 wen_q;
    logic [REG_AW-1:0]    rd_q;
    logic [CPU_WIDTH-1:0] data_q;
    logic [CNT_W-1:0]     cnt_q;

    logic                 w_ready;
    logic                 w_cap;
    logic [CPU_WIDTH-1:0] w_shifted;
    logic [CPU_WIDTH-1:0] w_ld_data;
    logic [CPU_WIDTH-1:0] w_wb_data;
    logic                 w_ld_fill;
    int                   w_ld_msb;

    assign w_ready     = ~rst & (~vld_q | out_ready);
    assign up.in_ready = w_ready;
    assign w_cap       = up.in_valid & w_ready;

    // Bits above the format's MSB are replaced by the fill bit (sign or zero).
    always_comb begin
        w_shifted = up.in_lsu_rdata >> {up.in_addr_lo, 3'b000};
        w_ld_msb  = CPU_WIDTH - 1;
        w_ld_fill = 1'b0;
        case (up.in_ld_fmt)
            3'd0: begin w_ld_msb = 7;  w_ld_fill = w_shifted[7];  end
            3'd1: begin w_ld_msb = 15; w_ld_fill = w_shifted[15]; end
            3'd2: begin w_ld_msb = 31; w_ld_fill = w_shifted[31]; end
            3'd4: w_ld_msb = 7;
            3'd5: w_ld_msb = 15;
            3'd6: w_ld_msb = 31;
            default: w_ld_msb = CPU_WIDTH - 1;
        endcase
        w_ld_data = w_shifted;
        for (int i = 0; i < CPU_WIDTH; i++) begin
            if (i > w_ld_msb) begin
                w_ld_data[i] = w_ld_fill;
            end
        end
    end

    always_comb begin
        case (up.in_wb_sel)
            2'd0:    w_wb_data = up.in_exu_res;
            2'd1:    w_wb_data = w_ld_data;
            2'd2:    w_wb_data = up.in_csr_rdata;
            default: w_wb_data = up.in_pc + CPU_WIDTH'(4);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= 1'b0;
            wen_q  <= 1'b0;
            rd_q   <= '0;
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (w_cap) begin
                vld_q  <= 1'b1;
                wen_q  <= up.in_rd_wen;
                rd_q   <= up.in_rd;
                data_q <= w_wb_data;
            end else if (out_ready) begin
                vld_q  <= 1'b0;
            end
            if (retire) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign retire     = vld_q & out_ready;
    assign rf_wen     = retire & wen_q & (rd_q != '0);
    assign rf_waddr   = rd_q;
    assign rf_wdata   = data_q;
    assign retire_cnt = cnt_q;

`ifdef YSYX_23060191_WBU_TRACE_EN
    logic [CPU_WIDTH-1:0] pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= '0;
        end else if (w_cap) begin
            pc_q <= up.in_pc;
        end
    end

    assign trace_valid = retire;
    assign trace_pc    = pc_q;
    assign trace_rd    = rf_wen ? rd_q   : '0;
    assign trace_wdata = rf_wen ? data_q : '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ysyx_23060191_wbu_pipe.sv
// ============================================================================
// Module   : tb_ysyx_23060191_wbu_pipe
// Brief    : directed + random self-checking bench for the writeback stage
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ysyx_23060191_wbu_pipe;

    localparam int CPU_WIDTH = 32;
    localparam int REG_AW    = 5;
    localparam int CNT_W     = 4;

    logic                 clk;
    logic                 rst;
    logic                 out_ready;
    logic                 rf_wen;
    logic [REG_AW-1:0]    rf_waddr;
    logic [CPU_WIDTH-1:0] rf_wdata;
    logic                 retire;
    logic [CNT_W-1:0]     retire_cnt;
`ifdef YSYX_23060191_WBU_TRACE_EN
    logic                 trace_valid;
    logic [CPU_WIDTH-1:0] trace_pc;
    logic [REG_AW-1:0]    trace_rd;
    logic [CPU_WIDTH-1:0] trace_wdata;
`endif

    ysyx_23060191_wbu_pipe_if #(.CPU_WIDTH(CPU_WIDTH), .REG_AW(REG_AW)) u_if ();

    ysyx_23060191_wbu_pipe #(
        .CPU_WIDTH (CPU_WIDTH),
        .REG_AW    (REG_AW),
        .CNT_W     (CNT_W)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .up         (u_if.slave),
        .out_ready  (out_ready),
        .rf_wen     (rf_wen),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .retire     (retire),
        .retire_cnt (retire_cnt)
`ifdef YSYX_23060191_WBU_TRACE_EN
        ,
        .trace_valid (trace_valid),
        .trace_pc    (trace_pc),
        .trace_rd    (trace_rd),
        .trace_wdata (trace_wdata)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: what the stage should be holding after each edge.
    bit          m_vld;
    bit          m_wen;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    int          m_cnt;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_wb(logic [1:0] sel, logic [31:0] pc,
            logic [31:0] exu, logic [31:0] rdata, logic [31:0] csr,
            logic [1:0] addr, logic [2:0] fmt);
        longint sh;
        longint v;
        int     bits;
        bit     sgn;
        case (sel)
            2'd0: v = longint'(exu);
            2'd2: v = longint'(csr);
            2'd3: v = longint'(pc) + 4;
            default: begin
                sh   = longint'(rdata) >> (8 * int'(addr));
                bits = (fmt == 0 || fmt == 4) ? 8 : (fmt == 1 || fmt == 5) ? 16 : 32;
                sgn  = (fmt <= 2);
                v    = sh & ((longint'(1) << bits) - 1);
                if (sgn && v >= (longint'(1) << (bits - 1)))
                    v = v - (longint'(1) << bits);
            end
        endcase
        return v[31:0];
    endfunction

    task automatic issue(logic [1:0] sel, logic [31:0] pc, logic [31:0] exu,
            logic [31:0] rdata, logic [31:0] csr, logic [1:0] addr,
            logic [2:0] fmt, logic [4:0] rd, logic wen);
        u_if.in_valid     = 1'b1;
        u_if.in_wb_sel    = sel;
        u_if.in_pc        = pc;
        u_if.in_exu_res   = exu;
        u_if.in_lsu_rdata = rdata;
        u_if.in_csr_rdata = csr;
        u_if.in_addr_lo   = addr;
        u_if.in_ld_fmt    = fmt;
        u_if.in_rd        = rd;
        u_if.in_rd_wen    = wen;
    endtask

    // Check combinational outputs against the reference, then advance one edge.
    task automatic tick();
        bit exp_ready;
        bit exp_ret;
        bit exp_wen;
        #1;
        exp_ready = !rst && (!m_vld || out_ready);
        exp_ret   = m_vld && out_ready;
        exp_wen   = exp_ret && m_wen && (m_rd != 0);
        chk("in_ready",   64'(u_if.in_ready), 64'(exp_ready));
        chk("retire",     64'(retire), 64'(exp_ret));
        chk("rf_wen",     64'(rf_wen), 64'(exp_wen));
        chk("retire_cnt", 64'(retire_cnt), 64'(m_cnt));
        if (m_vld) begin
            chk("rf_waddr", 64'(rf_waddr), 64'(m_rd));
            chk("rf_wdata", 64'(rf_wdata), 64'(m_data));
        end
        @(posedge clk);
        if (rst) begin
            m_vld = 0; m_wen = 0; m_rd = '0; m_data = '0; m_cnt = 0;
        end else begin
            if (exp_ret) m_cnt = (m_cnt + 1) % 16;
            if (u_if.in_valid && exp_ready) begin
                m_vld  = 1;
                m_wen  = u_if.in_rd_wen;
                m_rd   = u_if.in_rd;
                m_data = model_wb(u_if.in_wb_sel, u_if.in_pc, u_if.in_exu_res,
                                  u_if.in_lsu_rdata, u_if.in_csr_rdata,
                                  u_if.in_addr_lo, u_if.in_ld_fmt);
            end else if (out_ready) begin
                m_vld = 0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] saved;
        int          cnt0;

        rst = 1'b1;
        out_ready = 1'b0;
        issue(2'd0, '0, '0, '0, '0, 2'd0, 3'd0, 5'd0, 1'b0);
        u_if.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        m_vld = 0; m_wen = 0; m_rd = '0; m_data = '0; m_cnt = 0;

        // Reset state, and a valid offered under reset must not be taken.
        issue(2'd0, '0, 32'hDEAD, '0, '0, 2'd0, 3'd0, 5'd7, 1'b1);
        out_ready = 1'b1;
        tick();
        chk("rst_waddr", 64'(rf_waddr), 64'h0);
        chk("rst_wdata", 64'(rf_wdata), 64'h0);
        chk("rst_retire", 64'(retire), 64'h0);
        rst = 1'b0;
        u_if.in_valid = 1'b0;
        tick();

        // EXU result
        issue(2'd0, 32'h100, 32'h1234, '0, '0, 2'd0, 3'd0, 5'd5, 1'b1);
        tick();
        u_if.in_valid = 1'b0;
        #1;
        chk("t1_wdata", 64'(rf_wdata), 64'h1234);
        chk("t1_wen",   64'(rf_wen), 64'h1);
        chk("t1_waddr", 64'(rf_waddr), 64'h5);
        chk("t1_cnt0",  64'(retire_cnt), 64'h0);
        tick();
        chk("t1_cnt1",  64'(retire_cnt), 64'h1);

        // Load formatting
        issue(2'd1, '0, '0, 32'h80FF7F01, '0, 2'd3, 3'd0, 5'd6, 1'b1);
        tick();
        chk("lb", 64'(rf_wdata), 64'hFFFFFF80);
        issue(2'd1, '0, '0, 32'h80FF7F01, '0, 2'd3, 3'd4, 5'd6, 1'b1);
        tick();
        chk("lbu", 64'(rf_wdata), 64'h00000080);
        issue(2'd1, '0, '0, 32'h80FF7F01, '0, 2'd2, 3'd1, 5'd6, 1'b1);
        tick();
        chk("lh", 64'(rf_wdata), 64'hFFFF80FF);

        // PC+4 wraps; x0 write suppressed but still retires
        issue(2'd3, 32'hFFFFFFFC, '0, '0, '0, 2'd0, 3'd0, 5'd0, 1'b1);
        tick();
        u_if.in_valid = 1'b0;
        #1;
        chk("pc4_wdata",  64'(rf_wdata), 64'h0);
        chk("pc4_rf_wen", 64'(rf_wen), 64'h0);
        chk("pc4_retire", 64'(retire), 64'h1);
        tick();

        // Back-to-back flow
        cnt0 = m_cnt;
        for (int i = 0; i < 4; i++) begin
            issue(2'd2, '0, '0, '0, 32'hC000 + 32'(i), 2'd0, 3'd0, 5'(i + 1), 1'b1);
            tick();
        end
        u_if.in_valid = 1'b0;
        tick();
        chk("b2b_cnt", 64'(retire_cnt), 64'((cnt0 + 4) % 16));

        // Stall holds the stage
        issue(2'd0, '0, 32'hABCD0001, '0, '0, 2'd0, 3'd0, 5'd9, 1'b1);
        tick();
        saved = rf_wdata;
        out_ready = 1'b0;
        issue(2'd0, '0, 32'h55555555, '0, '0, 2'd0, 3'd0, 5'd10, 1'b1);
        repeat (3) tick();
        chk("stall_hold", 64'(rf_wdata), 64'(saved));
        out_ready = 1'b1;
        u_if.in_valid = 1'b0;
        tick();
        tick();

        // Counter wrap over 16 retires
        cnt0 = m_cnt;
        for (int i = 0; i < 16; i++) begin
            issue(2'd0, '0, 32'(i), '0, '0, 2'd0, 3'd0, 5'd3, 1'b1);
            tick();
        end
        u_if.in_valid = 1'b0;
        tick();
        chk("wrap_cnt", 64'(retire_cnt), 64'(cnt0));

        // Reset while holding an unretired instruction
        issue(2'd0, '0, 32'h77, '0, '0, 2'd0, 3'd0, 5'd4, 1'b1);
        tick();
        out_ready = 1'b0;
        rst = 1'b1;
        tick();
        chk("mid_rst_wen",    64'(rf_wen), 64'h0);
        chk("mid_rst_retire", 64'(retire), 64'h0);
        chk("mid_rst_waddr",  64'(rf_waddr), 64'h0);
        chk("mid_rst_wdata",  64'(rf_wdata), 64'h0);
        chk("mid_rst_cnt",    64'(retire_cnt), 64'h0);
        chk("mid_rst_ready",  64'(u_if.in_ready), 64'h0);
        rst = 1'b0;
        u_if.in_valid = 1'b0;
        tick();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            issue(2'($urandom), $urandom, $urandom, $urandom, $urandom,
                  2'($urandom), 3'($urandom), 5'($urandom), 1'($urandom));
            u_if.in_valid = ($urandom_range(0, 3) != 0);
            out_ready     = ($urandom_range(0, 3) != 0);
            rst           = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ysyx_23060191_wbu_pipe.md
Name: ysyx_23060191_wbu_pipe

Overview:
Registered, handshaked writeback stage. It replaces the purely combinational result pass-through.
- Selects the writeback source: ALU result, load data, CSR read data or PC+4.
- Aligns and sign/zero-extends load data.
- Holds one instruction in a stage register and drives the register-file write port.
- Keeps a retired-instruction counter.
It sits between LSU (upstream, valid/ready) and the register file / commit logic (downstream).

Parameters:
CPU_WIDTH, 32, datapath width; legal values 32 or 64
REG_AW, 5, register-file address width
CNT_W, 64, retired-instruction counter width
Derived: OFF_W = log2(CPU_WIDTH/8), the byte-offset width (2 or 3)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  upstream instruction valid
in_ready  out  1  stage can accept
in_pc  in  CPU_WIDTH  instruction PC
in_exu_res  in  CPU_WIDTH  EXU result
in_lsu_rdata  in  CPU_WIDTH  raw memory read word
in_csr_rdata  in  CPU_WIDTH  CSR read data
in_addr_lo  in  OFF_W  load address low bits
in_wb_sel  in  2  source select: 0=EXU, 1=LOAD, 2=CSR, 3=PC+4
in_ld_fmt  in  3  load format: 0=LB, 1=LH, 2=LW, 3=LD, 4=LBU, 5=LHU, 6=LWU
in_rd  in  REG_AW  destination register
in_rd_wen  in  1  instruction writes rd
out_ready  in  1  commit side ready to retire
rf_wen  out  1  register-file write enable
rf_waddr  out  REG_AW  register-file write address
rf_wdata  out  CPU_WIDTH  register-file write data
retire  out  1  one-cycle pulse per retired instruction
retire_cnt  out  CNT_W  retired-instruction count

Behaviour:
- Clock and reset are decided: one clock `clk`; `rst` is synchronous and active-high.
- Reset values:
  - vld_q=0, retire_cnt=0, rf_wen=0, retire=0.
  - rf_waddr=0, rf_wdata=0.
  - All stage data registers cleared.
- Handshake:
  - in_ready = !vld_q | out_ready. This is combinational, with no bubble under continuous flow.
  - Capture when in_valid & in_ready.
  - On capture, vld_q <= 1 next cycle, and the stage registers load the formatted writeback data, rd and wen.
  - If there is no capture and out_ready=1, vld_q <= 0.
- Latency: one cycle from the input handshake to rf_wen/retire.
- Stall: vld_q=1 & out_ready=0 holds all stage registers. in_ready stays 0 until the stage retires.
- Retire: retire = vld_q & out_ready, combinational from the registered state.
- Register-file write: rf_wen = retire & wen_q & (rd_q != 0). x0 writes are suppressed; retire still pulses for them.
- Output validity: rf_waddr = rd_q and rf_wdata = data_q, driven from registers. Both are valid whenever vld_q=1.
- Source formatting (done before the stage register):
  - PC+4 is computed modulo 2^CPU_WIDTH.
  - LOAD: shifted = rdata >> (8*addr_lo).
  - Signed formats sign-extend from bit 7, 15 or 31 of `shifted`. LBU, LHU and LWU zero-extend.
  - LD, and LW when CPU_WIDTH=32, pass the data through unchanged.
  - LD or LWU when CPU_WIDTH=32 behaves as LW. Reserved code 7 behaves as LD.
- Misalignment: no detection. The shift uses addr_lo as given.
- Counter: retire_cnt increments by 1 on each retire and wraps from all-ones to 0.
- Reset mid-operation: a held, unretired instruction is discarded, with no rf_wen.
- Reset priority: rst=1 with in_valid=1 captures nothing. in_ready is forced to 0 while rst=1.

Optional Feature:
Macro: YSYX_23060191_WBU_TRACE_EN
- Defined:
  - Adds outputs trace_valid (1), trace_pc (CPU_WIDTH), trace_rd (REG_AW) and trace_wdata (CPU_WIDTH) for difftest.
  - trace_valid = retire. trace_pc holds the registered PC of the retiring instruction.
  - trace_rd and trace_wdata are rd_q and data_q; they read 0 when rf_wen=0.
  - The PC register is reset to 0.
- Undefined: these ports and the PC stage register are absent. All other behaviour is identical.

Test Plan:
1. Reset, then EXU op: exu_res=0x1234, rd=5, wen=1, out_ready=1 -> next cycle rf_wen=1, waddr=5, wdata=0x1234, retire=1, retire_cnt 0->1.
2. LB: rdata=0x80FF7F01, addr_lo=3 -> wdata=0xFFFFFF80. Same with LBU -> 0x00000080. LH with addr_lo=2 -> 0xFFFF80FF.
3. PC+4: pc=0xFFFFFFFC, sel=3 -> wdata=0x00000000. rd=0, wen=1 -> rf_wen=0 but retire=1.
4. Back-to-back: in_valid=1 for 4 cycles, out_ready=1 -> 4 consecutive retire pulses, in_ready constantly 1.
5. Stall: out_ready=0 for 3 cycles while holding an instruction -> in_ready=0, outputs stable, no rf_wen. On out_ready=1 -> single retire.
6. Wrap and reset: with CNT_W=4, retire 16 times -> retire_cnt returns to 0. Assert rst while vld_q=1 and out_ready=0 -> no rf_wen, and all outputs are 0 the next cycle.
